// File: rtl/ysyx_23060061_axil_rr_arb.sv
// Two-master AXI-Lite round-robin arbiter sharing one downstream port, one transaction at a time.
// Define YSYX_23060061_ARB_PERF_EN to enable the per-master completed-transaction counters.
module ysyx_23060061_axil_rr_arb #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   // master 0 (IFU)
   input  logic [ADDR_W-1:0]   m0_araddr,
   input  logic                m0_arvalid,
   output logic                m0_arready,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic [1:0]          m0_rresp,
   output logic                m0_rvalid,
   input  logic                m0_rready,
   input  logic [ADDR_W-1:0]   m0_awaddr,
   input  logic                m0_awvalid,
   output logic                m0_awready,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_wstrb,
   input  logic                m0_wvalid,
   output logic                m0_wready,
   output logic [1:0]          m0_bresp,
   output logic                m0_bvalid,
   input  logic                m0_bready,
   // master 1 (LSU)
   input  logic [ADDR_W-1:0]   m1_araddr,
   input  logic                m1_arvalid,
   output logic                m1_arready,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic [1:0]          m1_rresp,
   output logic                m1_rvalid,
   input  logic                m1_rready,
   input  logic [ADDR_W-1:0]   m1_awaddr,
   input  logic                m1_awvalid,
   output logic                m1_awready,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   input  logic                m1_wvalid,
   output logic                m1_wready,
   output logic [1:0]          m1_bresp,
   output logic                m1_bvalid,
   input  logic                m1_bready,
   // shared downstream port
   output logic [ADDR_W-1:0]   s_araddr,
   output logic                s_arvalid,
   input  logic                s_arready,
   input  logic [DATA_W-1:0]   s_rdata,
   input  logic [1:0]          s_rresp,
   input  logic                s_rvalid,
   output logic                s_rready,
   output logic [ADDR_W-1:0]   s_awaddr,
   output logic                s_awvalid,
   input  logic                s_awready,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   output logic                s_wvalid,
   input  logic                s_wready,
   input  logic [1:0]          s_bresp,
   input  logic                s_bvalid,
   output logic                s_bready,
   output logic [31:0]         grant_cnt0,
   output logic [31:0]         grant_cnt1
);

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_t;

   state_t state, state_nx;
   logic   own, own_nx, lg, lg_nx;
   logic   aw_done, aw_done_nx, w_done, w_done_nx;
   logic   req0, req1, aw_hs, w_hs, txn_done;

   // owner-side view of the selected master
   logic [ADDR_W-1:0]   o_araddr, o_awaddr;
   logic [DATA_W-1:0]   o_wdata, o_rdata;
   logic [DATA_W/8-1:0] o_wstrb;
   logic                o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready;
   logic                o_arready, o_rvalid, o_awready, o_wready, o_bvalid;
   logic [1:0]          o_rresp, o_bresp;

   assign req0 = m0_arvalid | (m0_awvalid & m0_wvalid);
   assign req1 = m1_arvalid | (m1_awvalid & m1_wvalid);

   assign o_araddr  = own ? m1_araddr  : m0_araddr;
   assign o_arvalid = own ? m1_arvalid : m0_arvalid;
   assign o_rready  = own ? m1_rready  : m0_rready;
   assign o_awaddr  = own ? m1_awaddr  : m0_awaddr;
   assign o_awvalid = own ? m1_awvalid : m0_awvalid;
   assign o_wdata   = own ? m1_wdata   : m0_wdata;
   assign o_wstrb   = own ? m1_wstrb   : m0_wstrb;
   assign o_wvalid  = own ? m1_wvalid  : m0_wvalid;
   assign o_bready  = own ? m1_bready  : m0_bready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         own     <= 1'b0;
         lg      <= 1'b1;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         state   <= state_nx;
         own     <= own_nx;
         lg      <= lg_nx;
         aw_done <= aw_done_nx;
         w_done  <= w_done_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      own_nx     = own;
      lg_nx      = lg;
      aw_done_nx = aw_done;
      w_done_nx  = w_done;
      s_araddr   = '0;
      s_arvalid  = 1'b0;
      s_rready   = 1'b0;
      s_awaddr   = '0;
      s_awvalid  = 1'b0;
      s_wdata    = '0;
      s_wstrb    = '0;
      s_wvalid   = 1'b0;
      s_bready   = 1'b0;
      o_arready  = 1'b0;
      o_rdata    = '0;
      o_rresp    = '0;
      o_rvalid   = 1'b0;
      o_awready  = 1'b0;
      o_wready   = 1'b0;
      o_bresp    = '0;
      o_bvalid   = 1'b0;
      aw_hs      = 1'b0;
      w_hs       = 1'b0;
      txn_done   = 1'b0;
      case (state)
         IDLE: begin
            if (req0 | req1) begin
               own_nx   = (req0 & req1) ? ~lg : req1;
               state_nx = (own_nx ? m1_arvalid : m0_arvalid) ? RD_ADDR : WR_ADDR;
            end
         end
         RD_ADDR: begin
            s_araddr  = o_araddr;
            s_arvalid = o_arvalid;
            o_arready = s_arready;
            if (o_arvalid & s_arready) state_nx = RD_DATA;
         end
         RD_DATA: begin
            s_rready = o_rready;
            o_rdata  = s_rdata;
            o_rresp  = s_rresp;
            o_rvalid = s_rvalid;
            if (s_rvalid & o_rready) begin
               state_nx = IDLE;
               lg_nx    = own;
               txn_done = 1'b1;
            end
         end
         WR_ADDR: begin
            // each channel is masked once its handshake has been taken
            s_awaddr  = o_awaddr;
            s_awvalid = o_awvalid & ~aw_done;
            s_wdata   = o_wdata;
            s_wstrb   = o_wstrb;
            s_wvalid  = o_wvalid & ~w_done;
            o_awready = s_awready & ~aw_done;
            o_wready  = s_wready & ~w_done;
            aw_hs     = o_awvalid & ~aw_done & s_awready;
            w_hs      = o_wvalid & ~w_done & s_wready;
            if ((aw_done | aw_hs) & (w_done | w_hs)) begin
               state_nx   = WR_RESP;
               aw_done_nx = 1'b0;
               w_done_nx  = 1'b0;
            end else begin
               aw_done_nx = aw_done | aw_hs;
               w_done_nx  = w_done | w_hs;
            end
         end
         WR_RESP: begin
            s_bready = o_bready;
            o_bresp  = s_bresp;
            o_bvalid = s_bvalid;
            if (s_bvalid & o_bready) begin
               state_nx = IDLE;
               lg_nx    = own;
               txn_done = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign m0_arready = ~own & o_arready;
   assign m0_rdata   = own ? '0 : o_rdata;
   assign m0_rresp   = own ? '0 : o_rresp;
   assign m0_rvalid  = ~own & o_rvalid;
   assign m0_awready = ~own & o_awready;
   assign m0_wready  = ~own & o_wready;
   assign m0_bresp   = own ? '0 : o_bresp;
   assign m0_bvalid  = ~own & o_bvalid;

   assign m1_arready = own & o_arready;
   assign m1_rdata   = own ? o_rdata : '0;
   assign m1_rresp   = own ? o_rresp : '0;
   assign m1_rvalid  = own & o_rvalid;
   assign m1_awready = own & o_awready;
   assign m1_wready  = own & o_wready;
   assign m1_bresp   = own ? o_bresp : '0;
   assign m1_bvalid  = own & o_bvalid;

`ifdef YSYX_23060061_ARB_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else if (txn_done) begin
         if (own) grant_cnt1 <= grant_cnt1 + 32'd1;
         else     grant_cnt0 <= grant_cnt0 + 32'd1;
      end
   end
`else
   logic unused_done;
   assign unused_done = txn_done;
   assign grant_cnt0  = '0;
   assign grant_cnt1  = '0;
`endif

endmodule

// File: tb/tb_ysyx_23060061_axil_rr_arb.sv
// Directed bench for the AXI-Lite round-robin arbiter: vector table plus arbitration,
// split-handshake write and mid-transaction reset sequences.
module tb_ysyx_23060061_axil_rr_arb;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0][31:0] araddr, awaddr, wdata;
   logic [1:0][3:0]  wstrb;
   logic [1:0]       arvalid, rready, awvalid, wvalid, bready;
   wire  [1:0][31:0] rdata;
   wire  [1:0][1:0]  rresp, bresp;
   wire  [1:0]       arready, rvalid, awready, wready, bvalid;

   wire  [31:0] s_araddr, s_awaddr, s_wdata;
   wire  [3:0]  s_wstrb;
   wire         s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
   logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp, s_bresp;
   wire  [31:0] grant_cnt0, grant_cnt1;

   ysyx_23060061_axil_rr_arb #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst_n),
      .m0_araddr(araddr[0]), .m0_arvalid(arvalid[0]), .m0_arready(arready[0]),
      .m0_rdata(rdata[0]), .m0_rresp(rresp[0]), .m0_rvalid(rvalid[0]), .m0_rready(rready[0]),
      .m0_awaddr(awaddr[0]), .m0_awvalid(awvalid[0]), .m0_awready(awready[0]),
      .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_wvalid(wvalid[0]), .m0_wready(wready[0]),
      .m0_bresp(bresp[0]), .m0_bvalid(bvalid[0]), .m0_bready(bready[0]),
      .m1_araddr(araddr[1]), .m1_arvalid(arvalid[1]), .m1_arready(arready[1]),
      .m1_rdata(rdata[1]), .m1_rresp(rresp[1]), .m1_rvalid(rvalid[1]), .m1_rready(rready[1]),
      .m1_awaddr(awaddr[1]), .m1_awvalid(awvalid[1]), .m1_awready(awready[1]),
      .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_wvalid(wvalid[1]), .m1_wready(wready[1]),
      .m1_bresp(bresp[1]), .m1_bvalid(bvalid[1]), .m1_bready(bready[1]),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cnt_exp [2];

   typedef struct {
      int          m;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  resp;
      int          w_lead;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] quiet(input int o);
      return {arready[o], rvalid[o], awready[o], wready[o], bvalid[o]};
   endfunction

   task automatic chk_cnt(input string nm);
`ifdef YSYX_23060061_ARB_PERF_EN
      chk({nm, "_cnt0"}, 64'(grant_cnt0), 64'(cnt_exp[0]));
      chk({nm, "_cnt1"}, 64'(grant_cnt1), 64'(cnt_exp[1]));
`else
      chk({nm, "_cnt0"}, 64'(grant_cnt0), 64'd0);
      chk({nm, "_cnt1"}, 64'(grant_cnt1), 64'd0);
`endif
   endtask

   task automatic req_rd(input int m, input logic [31:0] a);
      arvalid[m] = 1'b1;
      araddr[m]  = a;
   endtask

   task automatic req_wr(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      awvalid[m] = 1'b1;
      wvalid[m]  = 1'b1;
      awaddr[m]  = a;
      wdata[m]   = d;
      wstrb[m]   = s;
   endtask

   // entered #1 after the edge that moved the arbiter into RD_ADDR; returns #1 after the edge back to IDLE
   task automatic rd_phase(input int m, input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
      chk("rd_s_arvalid", 64'(s_arvalid), 64'd1);
      chk("rd_s_araddr", 64'(s_araddr), 64'(a));
      s_arready = 1'b1;
      #1;
      chk("rd_arready", 64'(arready[m]), 64'd1);
      chk("rd_other_quiet_a", 64'(quiet(1 - m)), 64'd0);
      @(posedge clk); #1;
      arvalid[m] = 1'b0;
      s_arready  = 1'b0;
      s_rvalid   = 1'b1;
      s_rdata    = d;
      s_rresp    = r;
      #1;
      chk("rd_s_arvalid_off", 64'(s_arvalid), 64'd0);
      chk("rd_rvalid", 64'(rvalid[m]), 64'd1);
      chk("rd_rdata", 64'(rdata[m]), 64'(d));
      chk("rd_rresp", 64'(rresp[m]), 64'(r));
      chk("rd_s_rready", 64'(s_rready), 64'd1);
      chk("rd_other_quiet_r", 64'(quiet(1 - m)), 64'd0);
      @(posedge clk); #1;
      cnt_exp[m]++;
      chk("rd_rvalid_once", 64'(rvalid[m]), 64'd0);
      s_rvalid = 1'b0;
      s_rdata  = '0;
      s_rresp  = '0;
   endtask

   // w_lead>0: W accepted w_lead cycles before AW
   task automatic wr_phase(input int m, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] r, input int w_lead);
      chk("wr_s_awvalid", 64'(s_awvalid), 64'd1);
      chk("wr_s_wvalid", 64'(s_wvalid), 64'd1);
      chk("wr_s_awaddr", 64'(s_awaddr), 64'(a));
      chk("wr_s_wdata", 64'(s_wdata), 64'(d));
      chk("wr_s_wstrb", 64'(s_wstrb), 64'(s));
      chk("wr_other_quiet_a", 64'(quiet(1 - m)), 64'd0);
      if (w_lead == 0) begin
         s_awready = 1'b1;
         s_wready  = 1'b1;
         #1;
         chk("wr_aw_w_ready", 64'({awready[m], wready[m]}), 64'd3);
         @(posedge clk); #1;
      end else begin
         s_wready = 1'b1;
         #1;
         chk("wr_w_first", 64'({awready[m], wready[m]}), 64'd1);
         @(posedge clk); #1;
         s_wready = 1'b0;
         for (int i = 1; i < w_lead; i++) begin
            #1;
            chk("wr_wait_aw", 64'({s_awvalid, s_wvalid, s_bready}), 64'b100);
            @(posedge clk); #1;
         end
         s_awready = 1'b1;
         #1;
         chk("wr_aw_late", 64'({s_wvalid, awready[m], wready[m]}), 64'b010);
         @(posedge clk); #1;
      end
      s_awready  = 1'b0;
      s_wready   = 1'b0;
      awvalid[m] = 1'b0;
      wvalid[m]  = 1'b0;
      s_bvalid   = 1'b1;
      s_bresp    = r;
      #1;
      chk("wr_bvalid", 64'(bvalid[m]), 64'd1);
      chk("wr_bresp", 64'(bresp[m]), 64'(r));
      chk("wr_s_bready", 64'(s_bready), 64'd1);
      chk("wr_s_valids_off", 64'({s_awvalid, s_wvalid}), 64'd0);
      chk("wr_other_quiet_b", 64'(quiet(1 - m)), 64'd0);
      @(posedge clk); #1;
      cnt_exp[m]++;
      chk("wr_bvalid_once", 64'(bvalid[m]), 64'd0);
      s_bvalid = 1'b0;
      s_bresp  = '0;
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      cnt_exp[0] = 0;
      cnt_exp[1] = 0;
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      vec_t vecs [5];
      vecs[0] = '{m: 0, wr: 1'b0, addr: 32'h8000_0000, data: 32'hDEAD_BEEF, strb: 4'h0, resp: 2'b00, w_lead: 0};
      vecs[1] = '{m: 1, wr: 1'b1, addr: 32'hA000_03F8, data: 32'h0000_0041, strb: 4'b0001, resp: 2'b00, w_lead: 3};
      vecs[2] = '{m: 1, wr: 1'b0, addr: 32'h1000_0004, data: 32'h1234_5678, strb: 4'h0, resp: 2'b10, w_lead: 0};
      vecs[3] = '{m: 0, wr: 1'b1, addr: 32'h8000_0100, data: 32'hCAFE_F00D, strb: 4'b1111, resp: 2'b11, w_lead: 0};
      vecs[4] = '{m: 1, wr: 1'b1, addr: 32'h2000_0000, data: 32'h5555_AAAA, strb: 4'b1100, resp: 2'b01, w_lead: 1};

      araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
      arvalid = '0; awvalid = '0; wvalid = '0;
      rready = 2'b11; bready = 2'b11;
      s_arready = 1'b0; s_rvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
      s_rdata = '0; s_rresp = '0; s_bresp = '0;
      cnt_exp[0] = 0;
      cnt_exp[1] = 0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_s_outputs", 64'({s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}), 64'd0);
      chk("reset_m0_quiet", 64'(quiet(0)), 64'd0);
      chk("reset_m1_quiet", 64'(quiet(1)), 64'd0);
      chk("reset_data", 64'({rdata[0], rdata[1]}), 64'd0);
      chk_cnt("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) begin
         if (vecs[i].wr) req_wr(vecs[i].m, vecs[i].addr, vecs[i].data, vecs[i].strb);
         else            req_rd(vecs[i].m, vecs[i].addr);
         #1;
         chk("idle_no_s_valid", 64'({s_arvalid, s_awvalid, s_wvalid}), 64'd0);
         @(posedge clk); #1;
         if (vecs[i].wr) wr_phase(vecs[i].m, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp, vecs[i].w_lead);
         else            rd_phase(vecs[i].m, vecs[i].addr, vecs[i].data, vecs[i].resp);
      end
      chk_cnt("table");

      // round robin from reset: tie goes to m0, then m1 wins the next tie
      reset_pulse();
      req_rd(0, 32'h0000_1000);
      req_rd(1, 32'h0000_2000);
      @(posedge clk); #1;
      rd_phase(0, 32'h0000_1000, 32'h0000_00A0, 2'b00);
      req_rd(0, 32'h0000_3000);
      @(posedge clk); #1;
      rd_phase(1, 32'h0000_2000, 32'h0000_00B1, 2'b00);
      @(posedge clk); #1;
      rd_phase(0, 32'h0000_3000, 32'h0000_00C0, 2'b00);
      chk_cnt("rr");

      // read beats write within the same master
      req_rd(1, 32'h4000_0000);
      req_wr(1, 32'h4000_0010, 32'h0BAD_F00D, 4'b0011);
      @(posedge clk); #1;
      rd_phase(1, 32'h4000_0000, 32'h7777_0001, 2'b00);
      #1;
      chk("rd_then_wr_idle", 64'({s_awvalid, s_arvalid}), 64'd0);
      @(posedge clk); #1;
      wr_phase(1, 32'h4000_0010, 32'h0BAD_F00D, 4'b0011, 2'b00, 0);
      chk_cnt("rd_wr");

      // reset while data phase is pending
      req_rd(0, 32'h9000_0000);
      @(posedge clk); #1;
      s_arready = 1'b1;
      @(posedge clk); #1;
      s_arready  = 1'b0;
      arvalid[0] = 1'b0;
      s_rvalid   = 1'b1;
      s_rdata    = 32'hFEED_FACE;
      #1;
      chk("abort_pre_rvalid", 64'(rvalid[0]), 64'd1);
      rst_n = 1'b0;
      cnt_exp[0] = 0;
      cnt_exp[1] = 0;
      #1;
      chk("abort_outputs", 64'({rvalid[0], s_rready, s_arvalid}), 64'd0);
      chk("abort_rdata", 64'(rdata[0]), 64'd0);
      chk_cnt("abort");
      @(posedge clk); #1;
      chk("abort_next_cycle", 64'({rvalid[0], s_rready}), 64'd0);
      rst_n    = 1'b1;
      s_rvalid = 1'b0;
      s_rdata  = '0;
      @(posedge clk); #1;
      chk("abort_no_late_resp", 64'(quiet(0)), 64'd0);
      req_rd(1, 32'h9000_0040);
      @(posedge clk); #1;
      rd_phase(1, 32'h9000_0040, 32'h0000_0042, 2'b00);
      chk_cnt("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, limit 200000 required less");
      $fatal(1, "timeout");
   end

endmodule
